// File: rtl/ex_stage.sv
// Execute stage of the RV32 core: single-cycle ALU/branch unit plus an iterative
// restoring divider that stalls the front end through hold_o while it runs.
module ex_stage #(
  parameter int XLEN       = 32,
  parameter int DIV_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] inst_i,
  input  logic [XLEN-1:0] inst_addr_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            reg_wen_i,
  output logic [4:0]      rd_addr_o,
  output logic [XLEN-1:0] rd_data_o,
  output logic            rd_wen_o,
  output logic [XLEN-1:0] jump_addr_o,
  output logic            jump_en_o,
  output logic            hold_o
);

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int              CNT_W    = $clog2(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);

  // ------------------------------------------------------------------
  // Decode
  // ------------------------------------------------------------------
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic            is_muldiv;
  logic            is_div;
  logic [4:0]      shamt;
  logic [XLEN-1:0] b_imm;
  logic [XLEN-1:0] j_imm;

  assign opcode    = inst_i[6:0];
  assign funct3    = inst_i[14:12];
  assign funct7    = inst_i[31:25];
  assign is_muldiv = (opcode == OPC_OP) && (funct7 == F7_MULDIV);
  assign is_div    = is_muldiv && funct3[2];
  assign shamt     = op2_i[4:0];
  assign b_imm     = {{(XLEN-12){inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign j_imm     = {{(XLEN-20){inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

  // ------------------------------------------------------------------
  // ALU and comparators
  // ------------------------------------------------------------------
  logic            eq;
  logic            lt_s;
  logic            lt_u;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] sum;

  assign eq   = (op1_i == op2_i);
  assign lt_s = ($signed(op1_i) < $signed(op2_i));
  assign lt_u = (op1_i < op2_i);
  assign sum  = op1_i + op2_i;

  // SUB exists only in register-register form; ADDI ignores bit 30 of its immediate.
  always_comb begin
    alu_res = '0;
    case (funct3)
      3'b000:  alu_res = ((opcode == OPC_OP) && funct7[5]) ? (op1_i - op2_i) : sum;
      3'b001:  alu_res = op1_i << shamt;
      3'b010:  alu_res = {{(XLEN-1){1'b0}}, lt_s};
      3'b011:  alu_res = {{(XLEN-1){1'b0}}, lt_u};
      3'b100:  alu_res = op1_i ^ op2_i;
      3'b101:  alu_res = funct7[5] ? XLEN'($signed(op1_i) >>> shamt) : (op1_i >> shamt);
      3'b110:  alu_res = op1_i | op2_i;
      default: alu_res = op1_i & op2_i;
    endcase
  end

  logic br_taken;

  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000:  br_taken = eq;
      3'b001:  br_taken = !eq;
      3'b100:  br_taken = lt_s;
      3'b101:  br_taken = !lt_s;
      3'b110:  br_taken = lt_u;
      3'b111:  br_taken = !lt_u;
      default: br_taken = 1'b0;
    endcase
  end

  // ------------------------------------------------------------------
  // Single-cycle result selection
  // ------------------------------------------------------------------
  logic            ex_wen;
  logic [XLEN-1:0] ex_data;
  logic            ex_jen;
  logic [XLEN-1:0] ex_jaddr;

  always_comb begin
    ex_wen   = 1'b0;
    ex_data  = '0;
    ex_jen   = 1'b0;
    ex_jaddr = '0;
    case (opcode)
      OPC_OP_IMM: begin
        ex_wen  = reg_wen_i;
        ex_data = alu_res;
      end
      OPC_OP: begin
        if (!is_muldiv) begin
          ex_wen  = reg_wen_i;
          ex_data = alu_res;
        end
      end
      OPC_LUI: begin
        ex_wen  = reg_wen_i;
        ex_data = sum;
      end
      OPC_BRANCH: begin
        ex_jen   = br_taken;
        ex_jaddr = inst_addr_i + b_imm;
      end
      OPC_JAL: begin
        ex_wen   = reg_wen_i;
        ex_data  = inst_addr_i + XLEN'(4);
        ex_jen   = 1'b1;
        ex_jaddr = inst_addr_i + j_imm;
      end
      OPC_JALR: begin
        ex_wen   = reg_wen_i;
        ex_data  = inst_addr_i + XLEN'(4);
        ex_jen   = 1'b1;
        ex_jaddr = sum & ~XLEN'(1);
      end
      default: begin
        ex_wen = 1'b0;
        ex_jen = 1'b0;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Iterative divider
  // ------------------------------------------------------------------
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  quo_q, quo_d;
  logic [XLEN-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]  dvsr_q, dvsr_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             op_rem_q, op_rem_d;
  logic [4:0]       rd_q, rd_d;
  logic             wen_q, wen_d;

  logic             div_signed;
  logic             a_neg;
  logic             b_neg;
  logic [XLEN-1:0]  abs_a;
  logic [XLEN-1:0]  abs_b;

  assign div_signed = !funct3[0];
  assign a_neg      = div_signed && op1_i[XLEN-1];
  assign b_neg      = div_signed && op2_i[XLEN-1];
  assign abs_a      = a_neg ? (~op1_i + XLEN'(1)) : op1_i;
  assign abs_b      = b_neg ? (~op2_i + XLEN'(1)) : op2_i;

  // One restoring step: the partial remainder needs one extra bit before the trial subtract.
  logic [XLEN:0]   rem_shift;
  logic [XLEN:0]   trial;
  logic [XLEN-1:0] rem_step;
  logic [XLEN-1:0] quo_step;

  assign rem_shift = {rem_q, quo_q[XLEN-1]};
  assign trial     = rem_shift - {1'b0, dvsr_q};
  assign rem_step  = trial[XLEN] ? rem_shift[XLEN-1:0] : trial[XLEN-1:0];
  assign quo_step  = {quo_q[XLEN-2:0], !trial[XLEN]};

  logic div_start;
  assign div_start = (state_q == ST_IDLE) && is_div;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvsr_d   = dvsr_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    op_rem_d = op_rem_q;
    rd_d     = rd_q;
    wen_d    = wen_q;
    case (state_q)
      ST_IDLE: begin
        if (is_div) begin
          cnt_d    = '0;
          op_rem_d = funct3[1];
          rd_d     = rd_addr_i;
          wen_d    = reg_wen_i;
          dvsr_d   = abs_b;
          // A zero divisor yields the architectural results directly, with no sign fix-up.
          if (op2_i == '0) begin
            quo_d   = '1;
            rem_d   = op1_i;
            q_neg_d = 1'b0;
            r_neg_d = 1'b0;
            state_d = ST_DONE;
          end else begin
            quo_d   = abs_a;
            rem_d   = '0;
            q_neg_d = a_neg ^ b_neg;
            r_neg_d = a_neg;
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        quo_d = quo_step;
        rem_d = rem_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvsr_q   <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      op_rem_q <= 1'b0;
      rd_q     <= '0;
      wen_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dvsr_q   <= dvsr_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      op_rem_q <= op_rem_d;
      rd_q     <= rd_d;
      wen_q    <= wen_d;
    end
  end

  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;
  logic [XLEN-1:0] div_res;

  assign quo_fix = q_neg_q ? (~quo_q + XLEN'(1)) : quo_q;
  assign rem_fix = r_neg_q ? (~rem_q + XLEN'(1)) : rem_q;
  assign div_res = op_rem_q ? rem_fix : quo_fix;

  // ------------------------------------------------------------------
  // Outputs: everything that can disturb the pipeline is gated by reset
  // ------------------------------------------------------------------
  logic div_hold;
  assign div_hold = div_start || (state_q == ST_BUSY);

  always_comb begin
    rd_addr_o   = rd_addr_i;
    rd_data_o   = '0;
    rd_wen_o    = 1'b0;
    jump_addr_o = '0;
    jump_en_o   = 1'b0;
    hold_o      = 1'b0;
    if (rst) begin
      if (state_q == ST_DONE) begin
        rd_addr_o = rd_q;
        rd_data_o = div_res;
        rd_wen_o  = wen_q;
      end else if (div_hold) begin
        hold_o = 1'b1;
      end else begin
        rd_data_o   = ex_data;
        rd_wen_o    = ex_wen;
        jump_addr_o = ex_jaddr;
        jump_en_o   = ex_jen;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed vector table, randomized ALU/branch
// and divide traffic against a plain-arithmetic model, and multi-cycle corner cases.
module tb_ex_stage;

  logic        clk;
  logic        rst;
  logic [31:0] inst_i;
  logic [31:0] inst_addr_i;
  logic [31:0] op1_i;
  logic [31:0] op2_i;
  logic [4:0]  rd_addr_i;
  logic        reg_wen_i;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;
  logic        rd_wen_o;
  logic [31:0] jump_addr_o;
  logic        jump_en_o;
  logic        hold_o;

  int checks   = 0;
  int failures = 0;

  localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0]  OPC_OP     = 7'b0110011;
  localparam logic [31:0] NOP        = 32'h00000013;

  ex_stage dut (
    .clk         (clk),
    .rst         (rst),
    .inst_i      (inst_i),
    .inst_addr_i (inst_addr_i),
    .op1_i       (op1_i),
    .op2_i       (op2_i),
    .rd_addr_i   (rd_addr_i),
    .reg_wen_i   (reg_wen_i),
    .rd_addr_o   (rd_addr_o),
    .rd_data_o   (rd_data_o),
    .rd_wen_o    (rd_wen_o),
    .jump_addr_o (jump_addr_o),
    .jump_en_o   (jump_en_o),
    .hold_o      (hold_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [6:0] opc);
    return {f7, 5'd2, 5'd1, f3, 5'd3, opc};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [2:0] f3);
    return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
  endfunction

  // Reference divide built from the language's own signed/unsigned operators.
  function automatic logic [31:0] ref_div(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
    int signed sa, sb;
    logic [31:0] q, r;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      q = 32'hFFFFFFFF;
      r = a;
    end else if (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) begin
      q = 32'h80000000;
      r = 32'd0;
    end else if (!f3[0]) begin
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
    return f3[1] ? r : q;
  endfunction

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd;
    logic        wen;
    logic [31:0] data;
    logic        ewen;
    logic        ejen;
    logic [31:0] jaddr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [31:0] inst, input logic [31:0] pc,
                              input logic [31:0] op1, input logic [31:0] op2,
                              input logic [4:0] rd, input logic [31:0] data,
                              input logic ewen, input logic ejen, input logic [31:0] jaddr);
    vec_t v;
    v.inst = inst; v.pc = pc; v.op1 = op1; v.op2 = op2; v.rd = rd; v.wen = 1'b1;
    v.data = data; v.ewen = ewen; v.ejen = ejen; v.jaddr = jaddr;
    return v;
  endfunction

  task automatic drive(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic wen);
    @(negedge clk);
    inst_i = inst; inst_addr_i = pc; op1_i = a; op2_i = b; rd_addr_i = rd; reg_wen_i = wen;
    #1;
  endtask

  // Issues a divide, holds it on the inputs while hold_o is high, then checks the result.
  task automatic do_div(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input int exp_holds, input logic [31:0] exp_res);
    int holds;
    int stray;
    logic [4:0] rd;
    holds = 0;
    stray = 0;
    rd = 5'($urandom_range(1, 31));
    drive(enc_r(7'b0000001, f3, OPC_OP), 32'h1000, a, b, rd, 1'b1);
    for (int c = 0; c < 100; c++) begin
      if (!hold_o) break;
      holds++;
      if (rd_wen_o || jump_en_o) stray++;
      @(negedge clk);
      #1;
    end
    chk({name, "_hold_cycles"}, holds, exp_holds);
    chk({name, "_stray_wen"}, stray, 0);
    chk({name, "_wen"}, {31'd0, rd_wen_o}, 32'd1);
    chk({name, "_rd"}, {27'd0, rd_addr_o}, {27'd0, rd});
    chk({name, "_data"}, rd_data_o, exp_res);
    $display("txn div f3=%0d a=%h b=%h holds=%0d data=%h", f3, a, b, holds, rd_data_o);
    drive(NOP, 32'h1004, 32'd0, 32'd0, 5'd0, 1'b0);
    chk({name, "_no_restart"}, {31'd0, hold_o}, 32'd0);
  endtask

  initial begin
    logic [2:0]  f3;
    logic        imm_form;
    logic        alt;
    logic [31:0] a, b, exp, pc;
    logic [12:0] bimm;
    logic        taken;
    logic [2:0]  br_f3s [6];
    br_f3s = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};

    // Reset gates outputs even with a jumping instruction on the inputs.
    rst = 1'b0;
    inst_i = enc_j(21'd64); inst_addr_i = 32'h80; op1_i = 32'h5; op2_i = 32'h7;
    rd_addr_i = 5'd1; reg_wen_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_rd_wen", {31'd0, rd_wen_o}, 32'd0);
    chk("rst_jump_en", {31'd0, jump_en_o}, 32'd0);
    chk("rst_hold", {31'd0, hold_o}, 32'd0);
    chk("rst_rd_data", rd_data_o, 32'd0);
    chk("rst_jump_addr", jump_addr_o, 32'd0);
    $display("txn reset");
    rst = 1'b1;

    vecs.push_back(mk({12'hFFD, 5'd1, 3'b000, 5'd3, OPC_OP_IMM}, 32'h0, 32'd5, 32'hFFFFFFFD,
                      5'd3, 32'd2, 1'b1, 1'b0, 32'h0));
    vecs.push_back(mk(enc_b(13'd16, 3'b100), 32'h100, 32'hFFFFFFFF, 32'd1, 5'd0, 32'h0,
                      1'b0, 1'b1, 32'h110));
    vecs.push_back(mk(enc_b(13'd16, 3'b110), 32'h100, 32'hFFFFFFFF, 32'd1, 5'd0, 32'h0,
                      1'b0, 1'b0, 32'h0));
    vecs.push_back(mk(enc_b(13'h1FE0, 3'b101), 32'h400, 32'd5, 32'd5, 5'd0, 32'h0,
                      1'b0, 1'b1, 32'h3E0));
    vecs.push_back(mk(enc_r(7'b0100000, 3'b000, OPC_OP), 32'h0, 32'd3, 32'd5, 5'd4,
                      32'hFFFFFFFE, 1'b1, 1'b0, 32'h0));
    vecs.push_back(mk(enc_r(7'b0100000, 3'b101, OPC_OP), 32'h0, 32'h80000000, 32'd4, 5'd5,
                      32'hF8000000, 1'b1, 1'b0, 32'h0));
    vecs.push_back(mk(enc_r(7'b0000000, 3'b101, OPC_OP), 32'h0, 32'h80000000, 32'd4, 5'd6,
                      32'h08000000, 1'b1, 1'b0, 32'h0));
    vecs.push_back(mk(enc_r(7'b0000000, 3'b010, OPC_OP), 32'h0, 32'hFFFFFFFF, 32'd1, 5'd7,
                      32'd1, 1'b1, 1'b0, 32'h0));
    vecs.push_back(mk(enc_r(7'b0000000, 3'b011, OPC_OP), 32'h0, 32'hFFFFFFFF, 32'd1, 5'd8,
                      32'd0, 1'b1, 1'b0, 32'h0));
    vecs.push_back(mk(enc_r(7'b0000000, 3'b001, OPC_OP_IMM), 32'h0, 32'd3, 32'h21, 5'd9,
                      32'd6, 1'b1, 1'b0, 32'h0));
    vecs.push_back(mk({20'h12345, 5'd5, 7'b0110111}, 32'h0, 32'h12345000, 32'd0, 5'd10,
                      32'h12345000, 1'b1, 1'b0, 32'h0));
    vecs.push_back(mk(enc_j(21'h1FFFF8), 32'h200, 32'd0, 32'd0, 5'd1, 32'h204,
                      1'b1, 1'b1, 32'h1F8));
    vecs.push_back(mk({12'h004, 5'd1, 3'b000, 5'd1, 7'b1100111}, 32'h300, 32'h1001, 32'h4,
                      5'd1, 32'h304, 1'b1, 1'b1, 32'h1004));
    vecs.push_back(mk(enc_r(7'b0000001, 3'b000, OPC_OP), 32'h0, 32'd3, 32'd5, 5'd11,
                      32'h0, 1'b0, 1'b0, 32'h0));
    vecs.push_back(mk(32'hFFFFFFFF, 32'h0, 32'd3, 32'd5, 5'd12, 32'h0, 1'b0, 1'b0, 32'h0));
    vecs.push_back(mk(enc_r(7'b0000000, 3'b000, OPC_OP), 32'h0, 32'd1, 32'd2, 5'd0,
                      32'd3, 1'b1, 1'b0, 32'h0));

    foreach (vecs[i]) begin
      drive(vecs[i].inst, vecs[i].pc, vecs[i].op1, vecs[i].op2, vecs[i].rd, vecs[i].wen);
      chk($sformatf("vec%0d_wen", i), {31'd0, rd_wen_o}, {31'd0, vecs[i].ewen});
      chk($sformatf("vec%0d_jen", i), {31'd0, jump_en_o}, {31'd0, vecs[i].ejen});
      chk($sformatf("vec%0d_hold", i), {31'd0, hold_o}, 32'd0);
      chk($sformatf("vec%0d_rd", i), {27'd0, rd_addr_o}, {27'd0, vecs[i].rd});
      if (vecs[i].ewen) chk($sformatf("vec%0d_data", i), rd_data_o, vecs[i].data);
      if (vecs[i].ejen) chk($sformatf("vec%0d_jaddr", i), jump_addr_o, vecs[i].jaddr);
      $display("txn vec%0d inst=%h data=%h jen=%0d jaddr=%h", i, vecs[i].inst, rd_data_o,
               jump_en_o, jump_addr_o);
    end

    // Randomized ALU traffic.
    for (int n = 0; n < 60; n++) begin
      f3 = 3'($urandom_range(0, 7));
      imm_form = 1'($urandom_range(0, 1));
      alt = 1'($urandom_range(0, 1));
      a = $urandom();
      b = (n % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom();
      case (f3)
        3'd0: exp = (!imm_form && alt) ? a - b : a + b;
        3'd1: exp = a << b[4:0];
        3'd2: exp = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        3'd3: exp = (a < b) ? 32'd1 : 32'd0;
        3'd4: exp = a ^ b;
        3'd5: exp = alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
        3'd6: exp = a | b;
        default: exp = a & b;
      endcase
      drive(enc_r({1'b0, alt, 5'd0}, f3, imm_form ? OPC_OP_IMM : OPC_OP), 32'h0, a, b,
            5'd13, 1'b1);
      chk($sformatf("alu%0d_data", n), rd_data_o, exp);
      chk($sformatf("alu%0d_wen", n), {31'd0, rd_wen_o}, 32'd1);
      $display("txn alu f3=%0d imm=%0d alt=%0d a=%h b=%h data=%h", f3, imm_form, alt, a, b,
               rd_data_o);
    end

    // Randomized branches.
    for (int n = 0; n < 40; n++) begin
      f3 = br_f3s[$urandom_range(0, 5)];
      a = $urandom();
      b = ($urandom_range(0, 3) == 0) ? a : $urandom();
      bimm = {12'($urandom()), 1'b0};
      pc = {$urandom_range(0, 32'h3FFFFFFF), 2'b00};
      case (f3)
        3'd0: taken = (a == b);
        3'd1: taken = (a != b);
        3'd4: taken = ($signed(a) < $signed(b));
        3'd5: taken = ($signed(a) >= $signed(b));
        3'd6: taken = (a < b);
        default: taken = (a >= b);
      endcase
      drive(enc_b(bimm, f3), pc, a, b, 5'd14, 1'b1);
      chk($sformatf("br%0d_jen", n), {31'd0, jump_en_o}, {31'd0, taken});
      chk($sformatf("br%0d_wen", n), {31'd0, rd_wen_o}, 32'd0);
      if (taken) chk($sformatf("br%0d_jaddr", n), jump_addr_o, pc + {{19{bimm[12]}}, bimm});
      $display("txn br f3=%0d a=%h b=%h taken=%0d jaddr=%h", f3, a, b, jump_en_o, jump_addr_o);
    end

    // Directed divides.
    do_div("div_neg", 3'b100, 32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFD);
    do_div("rem_neg", 3'b110, 32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFF);
    do_div("divu_zero", 3'b101, 32'h1234, 32'd0, 1, 32'hFFFFFFFF);
    do_div("remu_zero", 3'b111, 32'h1234, 32'd0, 1, 32'h1234);
    do_div("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 33, 32'h80000000);
    do_div("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 33, 32'h0);
    do_div("rem_zero_neg", 3'b110, 32'hFFFFFFFB, 32'd0, 1, 32'hFFFFFFFB);

    // Randomized divides.
    for (int n = 0; n < 8; n++) begin
      f3 = {1'b1, 2'($urandom_range(0, 3))};
      a = $urandom();
      b = (n == 3) ? 32'd0 : ((n % 2 == 0) ? $urandom() : 32'($urandom_range(1, 1000)));
      do_div($sformatf("rdiv%0d", n), f3, a, b, (b == 0) ? 1 : 33, ref_div(f3, a, b));
    end

    // Reset in the middle of a divide abandons it.
    drive(enc_r(7'b0000001, 3'b100, OPC_OP), 32'h2000, 32'd100, 32'd3, 5'd15, 1'b1);
    repeat (10) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_hold", {31'd0, hold_o}, 32'd0);
    chk("midrst_wen", {31'd0, rd_wen_o}, 32'd0);
    $display("txn reset mid-divide");
    @(negedge clk);
    rst = 1'b1;
    inst_i = enc_r(7'b0000000, 3'b000, OPC_OP); op1_i = 32'd7; op2_i = 32'd8;
    rd_addr_i = 5'd9; reg_wen_i = 1'b1;
    #1;
    chk("post_rst_add_data", rd_data_o, 32'd15);
    chk("post_rst_add_wen", {31'd0, rd_wen_o}, 32'd1);
    chk("post_rst_add_hold", {31'd0, hold_o}, 32'd0);
    $display("txn add after reset data=%h", rd_data_o);
    do_div("post_rst_div", 3'b101, 32'd100, 32'd3, 33, 32'd33);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage RV32 core; consumes the registered id_ex outputs and drives regfile writeback plus branch/jump redirect to pc/if_id.
- Single-cycle ALU and branch unit for RV32I integer ops, plus an iterative 32-cycle divider (DIV/DIVU/REM/REMU) that stalls the front end through hold_o.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- DIV_CYCLES, 32, divider iteration count; must equal XLEN.

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  synchronous reset, active-low.
- inst_i  input  32  instruction from id_ex; NOP is 32'h00000013.
- inst_addr_i  input  32  PC of inst_i.
- op1_i  input  32  operand 1 from ID: rs1, or U-imm for LUI.
- op2_i  input  32  operand 2 from ID: rs2, sign-extended I-imm, or 0 for LUI.
- rd_addr_i  input  5  destination register.
- reg_wen_i  input  1  write enable from ID.
- rd_addr_o  output  5  writeback address.
- rd_data_o  output  32  writeback data.
- rd_wen_o  output  1  writeback enable.
- jump_addr_o  output  32  redirect target.
- jump_en_o  output  1  redirect valid; pc loads target, if_id/id_ex flush.
- hold_o  output  1  stall request; pc, if_id and id_ex hold contents while high.

Behaviour:
- Reset: one clock with rst==0 forces state=IDLE, iteration counter=0, divider regs=0. rd_wen_o, jump_en_o, hold_o, rd_data_o, jump_addr_o are forced 0 while rst==0.
- Non-divide ops: fully combinational, zero latency; rd_addr_o=rd_addr_i, rd_wen_o=reg_wen_i.
- OP-IMM/OP: ADD/ADDI, SUB (funct7[5]), SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND. Shift amount is op2_i[4:0]; SLT signed, SLTU unsigned.
- LUI: rd_data_o=op1_i+op2_i.
- Branches BEQ/BNE/BLT/BGE/BLTU/BGEU: compare op1_i vs op2_i. Taken -> jump_en_o=1, jump_addr_o=inst_addr_i+B-imm decoded from inst_i. No regfile write.
- JAL: rd_data_o=inst_addr_i+4; jump_addr_o=inst_addr_i+J-imm; jump_en_o=1.
- JALR: rd_data_o=inst_addr_i+4; jump_addr_o=(op1_i+op2_i)&~1; jump_en_o=1.
- MUL-group decodes (funct7=0000001, funct3[2]=0) and unknown opcodes: no write, no jump.
- Divide detect: opcode 0110011, funct7 0000001, funct3 1xx.
- FSM states: IDLE, BUSY, DONE.
  - IDLE, divide detected: hold_o=1 combinationally. Latch |op1|, |op2|, quotient/remainder result signs, op type, rd_addr_i, reg_wen_i. Go to BUSY, counter=0. If op2_i==0, go directly to DONE.
  - BUSY: hold_o=1. One restoring-division step per cycle (shift remainder/dividend left 1, trial-subtract divisor, set quotient bit). Counter increments; after step 32 (counter==31) go to DONE.
  - DONE: hold_o=0, rd_wen_o=latched reg_wen, rd_addr_o=latched rd, rd_data_o=signed-corrected quotient or remainder, jump_en_o=0. Return to IDLE next cycle. The same divide still sits on inst_i this cycle and must not restart.
  - Latency: divide occupies EX for 34 cycles (1 IDLE + 32 BUSY + 1 DONE). Divide by zero occupies 2 cycles.
- Sign rules: quotient negated when operand signs differ (signed ops only). Remainder takes the dividend's sign. All arithmetic is mod 2^32.
- Divide by zero: quotient=32'hFFFFFFFF; remainder=dividend (unmodified op1).
- Overflow: DIV 0x80000000 / 0xFFFFFFFF = 0x80000000; REM of the same = 0. This falls out of the unsigned magnitude path and needs no special case.
- During IDLE-detect and BUSY: rd_wen_o=0, jump_en_o=0.
- Reset mid-divide: abandons the operation, no writeback, hold_o drops in the reset cycle.
- rd_addr x0: forwarded unchanged; the regfile ignores x0 writes.

Test Plan:
- ADDI: op1=5, op2=0xFFFFFFFD, rd=3 -> rd_data_o=2, rd_wen_o=1 same cycle; hold_o=0.
- BLT: op1=0xFFFFFFFF, op2=1, pc=0x100, B-imm=+16 -> jump_en_o=1, jump_addr_o=0x110, rd_wen_o=0. BLTU with the same operands -> jump_en_o=0.
- DIV: inst held, op1=-7, op2=2 -> hold_o=1 for 33 cycles. Cycle 34: rd_data_o=0xFFFFFFFD (-3), rd_wen_o=1, hold_o=0. REM with the same operands -> 0xFFFFFFFF (-1).
- DIVU by zero: op1=0x1234 -> hold_o high 1 cycle, then quotient 0xFFFFFFFF. REMU by zero -> 0x1234.
- DIV overflow: 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM of the same -> 0.
- Reset mid-divide: rst=0 at BUSY cycle 10 -> next cycle state IDLE, hold_o=0, no rd_wen_o pulse. A new ADD afterwards executes in 1 cycle.
